// File: rtl/updi_rsp_parser_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +-------------------------------------------------------------------------+
// | updi_pkg: shared UPDI frame layout, ACK value, error indices, FSM type.  |
// | Rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
package updi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT_RX = 3'd1,
    ST_READ    = 3'd2,
    ST_LATCH   = 3'd3,
    ST_CHECK   = 3'd4,
    ST_OUT     = 3'd5,
    ST_FINISH  = 3'd6
  } state_e;

  localparam int FRAME_W   = 12;
  localparam int DATA_W    = 8;
  localparam int START_BIT = 0;
  localparam int DATA_LSB  = 1;
  localparam int PAR_BIT   = 9;
  localparam int STOP_MSB  = 11;

  localparam logic [7:0] ACK_BYTE = 8'h40;

  localparam int ERR_PAR = 0;
  localparam int ERR_FRM = 1;
  localparam int ERR_TMO = 2;

  // Parity bit makes the total count of ones over data + parity even.
  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/updi_rsp_parser_if.sv
`timescale 1ns/1ps
`default_nettype none
// +-------------------------------------------------------------------------+
// | updi_rsp_parser_if: BUFF_MEM read port plus byte stream towards APP.     |
// | Rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
interface updi_rsp_parser_if;
  logic        o_csb;
  logic        o_web;
  logic [6:0]  o_addr;
  logic [11:0] i_mem_data;
  logic [7:0]  o_data;
  logic        o_valid;
  logic        i_ready;

  modport master (
    output o_csb, o_web, o_addr, o_data, o_valid,
    input  i_mem_data, i_ready
  );

  modport slave (
    input  o_csb, o_web, o_addr, o_data, o_valid,
    output i_mem_data, i_ready
  );
endinterface
`default_nettype wire

// File: rtl/updi_frame_check.sv
`timescale 1ns/1ps
`default_nettype none
// +-------------------------------------------------------------------------+
// | updi_frame_check: splits a 12-bit UART frame word, flags parity/framing. |
// | Rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
module updi_frame_check
  import updi_pkg::*;
(
  input  wire logic [FRAME_W-1:0] i_word,
  output logic      [DATA_W-1:0]  o_data,
  output logic                    o_par_err,
  output logic                    o_frm_err
);

  assign o_data    = i_word[DATA_LSB +: DATA_W];
  assign o_par_err = even_parity(o_data) != i_word[PAR_BIT];
  assign o_frm_err = i_word[START_BIT] | ~(&i_word[STOP_MSB -: 2]);

endmodule
`default_nettype wire

// File: rtl/updi_rsp_parser.sv
`timescale 1ns/1ps
`default_nettype none
// +-------------------------------------------------------------------------+
// | updi_rsp_parser: reads received frames from BUFF_MEM, checks them and    |
// | streams data bytes to APP. Rev 1.0                                       |
// +-------------------------------------------------------------------------+
module updi_rsp_parser
  import updi_pkg::*;
#(
  parameter logic [6:0] RX_BASE     = 7'd64,
  parameter int         MAX_LEN     = 16,
  parameter int         TIMEOUT_CYC = 65535,
  parameter logic [7:0] ACK_BYTE    = updi_pkg::ACK_BYTE
) (
  input  wire logic             i_clk,
  input  wire logic             i_resetn,
  input  wire logic             i_start,
  input  wire logic [4:0]       i_len,
  input  wire logic             i_ack_mode,
  output logic                  o_ren,
  input  wire logic             i_rend,
  updi_rsp_parser_if.master     bus,
  output logic                  o_done,
  output logic                  o_ack_ok,
  output logic [2:0]            o_err
);

  localparam int         TW        = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [5:0] MAX_LEN_W = 6'(MAX_LEN);

  state_e        state_q, state_d;
  logic [4:0]    len_q, len_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [4:0]    cnt_inc;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          ack_mode_q, ack_mode_d;
  logic [7:0]    byte_q, byte_d;
  logic          par_q, par_d;
  logic          frm_q, frm_d;
  logic          ren_q, ren_d;
  logic          csb_q, csb_d;
  logic [6:0]    addr_q, addr_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          done_q, done_d;
  logic          ack_ok_q, ack_ok_d;
  logic [2:0]    err_q, err_d;

  logic [7:0]    w_byte;
  logic          w_par_err;
  logic          w_frm_err;

  updi_frame_check u_frame_check (
    .i_word    (bus.i_mem_data),
    .o_data    (w_byte),
    .o_par_err (w_par_err),
    .o_frm_err (w_frm_err)
  );

  assign cnt_inc = cnt_q + 5'd1;

  // All outputs are registered: each is set on the transition into the
  // state where it must be visible.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    tmo_d      = tmo_q;
    ack_mode_d = ack_mode_q;
    byte_d     = byte_q;
    par_d      = par_q;
    frm_d      = frm_q;
    ren_d      = ren_q;
    csb_d      = csb_q;
    addr_d     = addr_q;
    data_d     = data_q;
    valid_d    = valid_q;
    done_d     = 1'b0;
    ack_ok_d   = ack_ok_q;
    err_d      = err_q;

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          len_d      = (i_len == 5'd0 || {1'b0, i_len} > MAX_LEN_W) ? 5'd1 : i_len;
          ack_mode_d = i_ack_mode;
          err_d      = 3'b000;
          ack_ok_d   = 1'b0;
          cnt_d      = 5'd0;
          tmo_d      = '0;
          ren_d      = 1'b1;
          state_d    = ST_WAIT_RX;
        end
      end
      ST_WAIT_RX: begin
        if (i_rend) begin
          ren_d   = 1'b0;
          csb_d   = 1'b0;
          addr_d  = RX_BASE + 7'(cnt_q);
          state_d = ST_READ;
        end else if (tmo_q == TMO_LAST) begin
          ren_d          = 1'b0;
          err_d[ERR_TMO] = 1'b1;
          done_d         = 1'b1;
          state_d        = ST_FINISH;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_READ: begin
        csb_d   = 1'b1;
        state_d = ST_LATCH;
      end
      ST_LATCH: begin
        byte_d  = w_byte;
        par_d   = w_par_err;
        frm_d   = w_frm_err;
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        err_d[ERR_PAR] = err_q[ERR_PAR] | par_q;
        err_d[ERR_FRM] = err_q[ERR_FRM] | frm_q;
        if (ack_mode_q) begin
          // The ACK byte is consumed here and never streamed.
          ack_ok_d = (byte_q == ACK_BYTE) && !par_q && !frm_q;
          done_d   = 1'b1;
          state_d  = ST_FINISH;
        end else begin
          data_d  = byte_q;
          valid_d = 1'b1;
          state_d = ST_OUT;
        end
      end
      ST_OUT: begin
        if (bus.i_ready) begin
          valid_d = 1'b0;
          cnt_d   = cnt_inc;
          if (cnt_inc == len_q) begin
            done_d  = 1'b1;
            state_d = ST_FINISH;
          end else begin
            csb_d   = 1'b0;
            addr_d  = RX_BASE + 7'(cnt_inc);
            state_d = ST_READ;
          end
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state_q    <= ST_IDLE;
      len_q      <= 5'd1;
      cnt_q      <= 5'd0;
      tmo_q      <= '0;
      ack_mode_q <= 1'b0;
      byte_q     <= 8'd0;
      par_q      <= 1'b0;
      frm_q      <= 1'b0;
      ren_q      <= 1'b0;
      csb_q      <= 1'b1;
      addr_q     <= RX_BASE;
      data_q     <= 8'd0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      ack_ok_q   <= 1'b0;
      err_q      <= 3'b000;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      ack_mode_q <= ack_mode_d;
      byte_q     <= byte_d;
      par_q      <= par_d;
      frm_q      <= frm_d;
      ren_q      <= ren_d;
      csb_q      <= csb_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      ack_ok_q   <= ack_ok_d;
      err_q      <= err_d;
    end
  end

  assign o_ren       = ren_q;
  assign bus.o_csb   = csb_q;
  assign bus.o_web   = 1'b1;
  assign bus.o_addr  = addr_q;
  assign bus.o_data  = data_q;
  assign bus.o_valid = valid_q;
  assign o_done      = done_q;
  assign o_ack_ok    = ack_ok_q;
  assign o_err       = err_q;

endmodule
`default_nettype wire
